// File: rtl/sram_controller_if.sv
// -----------------------------------------------------------------------------
// sram_controller_if
//   Word load/store request bus between the pipeline MEM stage (master) and
//   the SRAM controller (slave).
//
//   wr_en       store request
//   rd_en       load request
//   address     32-bit byte address, word aligned
//   write_data  store data
//   read_data   load result (registered in the controller)
//   ready       low = stall the pipeline, high = idle or access complete
// -----------------------------------------------------------------------------
interface sram_controller_if;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;

  modport master (
    output wr_en, rd_en, address, write_data,
    input  read_data, ready
  );

  modport slave (
    input  wr_en, rd_en, address, write_data,
    output read_data, ready
  );
endinterface

// File: rtl/sram_controller.sv
// -----------------------------------------------------------------------------
// sram_controller
//   Turns a 32-bit word load/store into two 16-bit accesses on an external
//   asynchronous SRAM (low half first, then high half), followed by
//   WAIT_CYCLES idle pad cycles and a one-cycle DONE. ready stays low for the
//   whole access so the pipeline freezes.
//
//   clk        system clock, rising edge
//   rst        asynchronous reset, active high
//   bus        request bus (slave side), see sram_controller_if
//   SRAM_DQ    16-bit bidirectional SRAM data, driven only during write halves
//   SRAM_ADDR  SRAM half-word address
//   SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_OE_N  tied low (always enabled)
//   SRAM_WE_N  SRAM write enable, active low
// -----------------------------------------------------------------------------
module sram_controller #(
  parameter logic [31:0] BASE_ADDR   = 32'd1024, // byte address of SRAM word 0
  parameter int unsigned WAIT_CYCLES = 2         // pad cycles, 0..15
) (
  input  logic             clk,
  input  logic             rst,
  sram_controller_if.slave bus,
  inout  wire  [15:0]      SRAM_DQ,
  output logic [17:0]      SRAM_ADDR,
  output logic             SRAM_UB_N,
  output logic             SRAM_LB_N,
  output logic             SRAM_CE_N,
  output logic             SRAM_OE_N,
  output logic             SRAM_WE_N
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACC_LO,
    S_ACC_HI,
    S_WAIT,
    S_DONE
  } state_e;

  // Terminal count of the pad counter; unused when WAIT_CYCLES is 0.
  localparam logic [3:0] LAST_WAIT = (WAIT_CYCLES == 0) ? 4'd0
                                                        : 4'(WAIT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [16:0] word_q,  word_d;   // SRAM word index of the access in flight
  logic [31:0] data_q,  data_d;   // latched store data
  logic        wr_op_q, wr_op_d;  // 1 = write, 0 = read
  logic [3:0]  cnt_q,   cnt_d;    // pad-cycle counter
  logic [31:0] rdata_q, rdata_d;  // load result

  logic ready;
  logic acc_hi;
  logic dq_drive;

  // NOTE: sequential state updates use non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      word_q  <= '0;
      data_q  <= '0;
      wr_op_q <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      data_q  <= data_d;
      wr_op_q <= wr_op_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  // NOTE: every signal assigned here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    data_d  = data_q;
    wr_op_d = wr_op_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    ready   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // ready drops in the same cycle the request appears so the pipeline
        // freezes before the requesting instruction moves on.
        ready = !(bus.wr_en || bus.rd_en);
        if (bus.wr_en || bus.rd_en) begin
          // Offset is taken mod 2^32; bits above the SRAM depth are dropped.
          word_d  = 17'((bus.address - BASE_ADDR) >> 2);
          data_d  = bus.write_data;
          wr_op_d = bus.wr_en;       // a store wins over a simultaneous load
          state_d = S_ACC_LO;
        end
      end
      S_ACC_LO: begin
        if (!wr_op_q) rdata_d[15:0] = SRAM_DQ;
        state_d = S_ACC_HI;
      end
      S_ACC_HI: begin
        if (!wr_op_q) rdata_d[31:16] = SRAM_DQ;
        cnt_d   = '0;
        state_d = (WAIT_CYCLES == 0) ? S_DONE : S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LAST_WAIT) state_d = S_DONE;
      end
      S_DONE: begin
        // Always return to IDLE: a request still held here is only seen again
        // from IDLE, which guarantees one idle cycle between accesses.
        ready   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign acc_hi   = (state_q == S_ACC_HI);
  // The SRAM drives DQ whenever WE_N is high, so the controller may only drive
  // it in exactly the cycles where it pulls WE_N low.
  assign dq_drive = wr_op_q && ((state_q == S_ACC_LO) || acc_hi);

  assign SRAM_ADDR = {word_q, acc_hi};
  assign SRAM_WE_N = !dq_drive;
  assign SRAM_DQ   = dq_drive ? (acc_hi ? data_q[31:16] : data_q[15:0]) : 16'hzzzz;

  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;

  assign bus.ready     = ready;
  assign bus.read_data = rdata_q;

endmodule

// File: doc/sram_controller.md
Name: sram_controller

Overview:
- Bridges the MEM stage's 32-bit word load/store requests to the off-chip 16-bit SRAM (18-bit address, active-low controls).
- Sequences each 32-bit access as two 16-bit SRAM cycles (low half, then high half), pads with wait cycles, and holds `ready` low so the hazard/freeze logic stalls the pipeline.
- Owns the `SRAM_DQ` tristate: drives it only while writing and releases it otherwise, because the SRAM drives DQ whenever `SRAM_WE_N` is high.

Parameters:
- BASE_ADDR, 1024: byte address mapped to SRAM word 0.
- WAIT_CYCLES, 2: idle pad cycles after the two half-accesses, before completion. Legal range 0..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- wr_en  input  1  store request from the MEM stage.
- rd_en  input  1  load request from the MEM stage.
- address  input  32  byte address, word-aligned.
- write_data  input  32  store data.
- read_data  output  32  load result, registered.
- ready  output  1  low = stall the pipeline; high = no access pending, or access complete.
- SRAM_DQ  inout  16  SRAM data bus.
- SRAM_ADDR  output  18  SRAM half-word address.
- SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_OE_N  output  1 each  tied 0.
- SRAM_WE_N  output  1  SRAM write enable, active low.

Behaviour:
- Clock and reset: one clock domain, `clk`. `rst` is asynchronous and active-high.
- Reset values:
  - state = IDLE.
  - `read_data` = 0. Internal address/data/op latches = 0. Wait counter = 0.
  - `SRAM_WE_N` = 1, `SRAM_ADDR` = 0, `SRAM_DQ` = Z.
  - `ready` = 1 when no request is present.
- Address mapping:
  - word = (address − BASE_ADDR) >> 2, computed mod 2^32.
  - Low half: `SRAM_ADDR` = {word[16:0], 0}. High half: `SRAM_ADDR` = {word[16:0], 1}.
  - Upper word bits are discarded, so addresses wrap silently.
- Request decode: `wr_en` has priority. `wr_en` & `rd_en` together is treated as a write.
- FSM states: IDLE, ACC_LO, ACC_HI, WAIT, DONE.
  - IDLE: if `wr_en` | `rd_en`, then `ready` = 0 combinationally in the same cycle. Latch address, `write_data` and op at the clock edge; next = ACC_LO. Otherwise `ready` = 1 and stay in IDLE.
  - ACC_LO: `SRAM_ADDR` = low address.
    - Write: `SRAM_WE_N` = 0, DQ driven with data[15:0].
    - Read: `SRAM_WE_N` = 1, DQ = Z, and `read_data[15:0]` captures DQ at the end-of-cycle edge.
    - Next = ACC_HI.
  - ACC_HI: same as ACC_LO with the high address and data[31:16]. Next = WAIT, or DONE if WAIT_CYCLES = 0. Counter loads 0.
  - WAIT: `SRAM_WE_N` = 1, DQ = Z, counter increments. Leave for DONE when counter = WAIT_CYCLES−1.
  - DONE: `ready` = 1 for exactly one cycle. Next = IDLE unconditionally. The request still asserted during DONE is not restarted.
- Latency: `ready` is low for 3 + WAIT_CYCLES cycles (5 by default) and high in the following cycle (DONE).
- `read_data`:
  - Holds its value until the next read overwrites it.
  - Writes never change it.
  - The upper half is updated one cycle after the lower half; only the value seen in DONE is guaranteed coherent.
- `SRAM_WE_N`: low only in ACC_LO/ACC_HI of a write. DQ is driven only under exactly that condition, so there is no bus contention.
- Request changes: request inputs may change after the IDLE latch edge with no effect on the access in flight.
- Reset mid-access: return to IDLE immediately with all reset values.
  - A partially written word (low half only) is left as is.
  - `read_data` is cleared.
- Back-to-back requests: a new request seen in IDLE the cycle after DONE starts a fresh access. There is a minimum of one IDLE cycle between accesses.

Test Plan:
- Write: address=1024, write_data=0xDEADBEEF, `wr_en`=1 → `ready` low for 5 cycles. Writes SRAM[0]=0xBEEF then SRAM[1]=0xDEAD with `SRAM_WE_N`=0 in exactly those 2 cycles. `ready` is high in the 6th cycle.
- Read-back: after the write above, `rd_en` at 1024 → `SRAM_ADDR` 0 then 1, DQ undriven by the controller. `read_data`=0xDEADBEEF in DONE.
- Second word: write 0x12345678 at 1028 → SRAM[2]=0x5678, SRAM[3]=0x1234. A read at 1028 returns 0x12345678; a read at 1024 still returns 0xDEADBEEF.
- Priority and no re-trigger: `wr_en`=`rd_en`=1 at 1032 with data 0xA5A55A5A → write performed and `read_data` unchanged. Holding the request through DONE yields exactly one extra access, starting after one IDLE cycle.
- Reset mid-write: assert `rst` during ACC_HI of a write of 0xCAFEF00D to 1036 → same-cycle IDLE, `SRAM_WE_N`=1, DQ=Z, `ready`=1, `read_data`=0. SRAM[6]=0xF00D, SRAM[7] unchanged.
- Parameter sweep: WAIT_CYCLES=0 → `ready` low for 3 cycles. WAIT_CYCLES=4 → 7 cycles. Data is correct in both cases.
